// File: rtl/mux_channel_scanner_if.sv
// Handshake/bus bundle between the channel scanner, the 8:1 mux and the sample consumer.
//   start, stop      scan control
//   chan_mask        enabled channels, bit k = channel k
//   s0, s1, s2       mux selects, {s2,s1,s0} = current channel
//   y_in             mux output fed back to the scanner
//   sample_data/chan captured sample and its channel
//   sample_valid     sample available; sample_ready = consumer accepts
//   busy             scanner not idle
//   frame_done       one-cycle pulse after the last channel of a pass is handed off
// Modport master is the scanner side, slave is the controller/consumer side.
interface mux_channel_scanner_if #(
  parameter int unsigned DATA_W = 4
);
  logic              start;
  logic              stop;
  logic [7:0]        chan_mask;
  logic              s0;
  logic              s1;
  logic              s2;
  logic [DATA_W-1:0] y_in;
  logic [DATA_W-1:0] sample_data;
  logic [2:0]        sample_chan;
  logic              sample_valid;
  logic              sample_ready;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, stop, chan_mask, y_in, sample_ready,
    output s0, s1, s2, sample_data, sample_chan, sample_valid, busy, frame_done
  );

  modport slave (
    output start, stop, chan_mask, y_in, sample_ready,
    input  s0, s1, s2, sample_data, sample_chan, sample_valid, busy, frame_done
  );
endinterface

// File: rtl/mux_channel_scanner.sv
// Round-robin sequencer for a 4-bit 8:1 mux. Steps over the enabled channels, waits DWELL
// settle cycles per channel, captures y_in and offers it with its channel number on a
// valid/ready stream.
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  mux_channel_scanner_if master modport (control, selects, y_in, sample stream)
// All outputs come straight from registers.
module mux_channel_scanner #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DWELL  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_channel_scanner_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e            state_q;
  logic [7:0]        mask_q;
  logic [2:0]        chan_q;
  logic [7:0]        cnt_q;
  logic              stop_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        sample_chan_q;
  logic              valid_q;
  logic              busy_q;
  logic              frame_done_q;

  logic [2:0] next_in_pass;
  logic       wrap;
  logic [7:0] next_mask;
  logic [2:0] next_chan;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  // Next enabled channel strictly above cur, wrapping 7->0; returns cur if it is the only one.
  function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    next_above = cur;
    for (int i = 7; i >= 1; i--) begin
      if (m[cur + 3'(i)]) next_above = cur + 3'(i);
    end
  endfunction

  always_comb begin
    next_in_pass = next_above(mask_q, chan_q);
    // A pass ends when the successor does not lie above the current channel.
    wrap         = (next_in_pass <= chan_q);
    next_mask    = wrap ? bus.chan_mask : mask_q;
    next_chan    = wrap ? lowest_set(bus.chan_mask) : next_in_pass;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      mask_q        <= 8'd0;
      chan_q        <= 3'd0;
      cnt_q         <= 8'd0;
      stop_q        <= 1'b0;
      data_q        <= '0;
      sample_chan_q <= 3'd0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // start beats a simultaneous stop; stop alone is ignored here.
          if (bus.start && (bus.chan_mask != 8'd0)) begin
            mask_q  <= bus.chan_mask;
            chan_q  <= lowest_set(bus.chan_mask);
            cnt_q   <= 8'd0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (bus.stop) stop_q <= 1'b1;
          if (cnt_q == 8'(DWELL - 1)) begin
            data_q        <= bus.y_in;
            sample_chan_q <= chan_q;
            valid_q       <= 1'b1;
            state_q       <= StHold;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (bus.stop) stop_q <= 1'b1;
          if (valid_q && bus.sample_ready) begin
            valid_q <= 1'b0;
            if (wrap) begin
              frame_done_q <= 1'b1;
              mask_q       <= bus.chan_mask;
            end
            // A stop arriving on the handshake cycle still counts for this sample.
            if (stop_q || bus.stop || (next_mask == 8'd0)) begin
              stop_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              chan_q  <= next_chan;
              cnt_q   <= 8'd0;
              state_q <= StSettle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s0           = chan_q[0];
  assign bus.s1           = chan_q[1];
  assign bus.s2           = chan_q[2];
  assign bus.sample_data  = data_q;
  assign bus.sample_chan  = sample_chan_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
module tb_mux_channel_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] y_xor = 4'h0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         lat;
  logic [3:0] held_data;

  mux_channel_scanner_if #(.DATA_W(4)) bus ();

  // Mux model: input i_k = k ^ y_xor.
  assign bus.y_in = {1'b0, bus.s2, bus.s1, bus.s0} ^ y_xor;

  mux_channel_scanner #(.DATA_W(4), .DWELL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (bus.sample_valid !== 1'b1 && l < 20) begin
      step();
      l++;
    end
  endtask

  // Expects sample_ready=1; consumes one sample and checks the post-handshake cycle.
  task automatic get_sample(input int c, input int d, input int fd, input int lat_exp);
    int l;
    wait_valid(l);
    chk("latency", l, lat_exp);
    chk("chan", {29'd0, bus.sample_chan}, c);
    chk("data", {28'd0, bus.sample_data}, d);
    chk("selects", {29'd0, bus.s2, bus.s1, bus.s0}, c);
    step();
    chk("frame_done", {31'd0, bus.frame_done}, fd);
    chk("valid_drop", {31'd0, bus.sample_valid}, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.sample_valid}, 0);
    chk({tag, "_data"}, {28'd0, bus.sample_data}, 0);
    chk({tag, "_chan"}, {29'd0, bus.sample_chan}, 0);
    chk({tag, "_sel"}, {29'd0, bus.s2, bus.s1, bus.s0}, 0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_fd"}, {31'd0, bus.frame_done}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.sample_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.chan_mask = 8'h00;
    bus.sample_ready = 1'b0;
    do_reset();
    chk_reset_outs("rst_init");

    // 1: async reset while holding a sample
    bus.chan_mask = 8'hFF;
    y_xor = 4'h5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(lat);
    chk("t1_valid", {31'd0, bus.sample_valid}, 1);
    chk("t1_data", {28'd0, bus.sample_data}, 5);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("t1_async");
    step();
    rst = 1'b0;

    // 2: full mask, identity mux, ready held high
    y_xor = 4'h0;
    bus.chan_mask = 8'hFF;
    bus.sample_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t2_busy", {31'd0, bus.busy}, 1);
    for (int k = 0; k < 9; k++) get_sample(k % 8, k % 8, (k == 7) ? 1 : 0, 2);

    // 3: sparse mask 2,5,7 then mask change mid-pass takes effect at the wrap
    do_reset();
    y_xor = 4'h5;
    bus.chan_mask = 8'b1010_0100;
    bus.sample_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    get_sample(2, 7, 0, 2);
    get_sample(5, 0, 0, 2);
    get_sample(7, 2, 1, 2);
    get_sample(2, 7, 0, 2);
    bus.chan_mask = 8'hFF;
    get_sample(5, 0, 0, 2);
    get_sample(7, 2, 1, 2);
    get_sample(0, 5, 0, 2);

    // 4: back-pressure for 5 cycles
    do_reset();
    bus.chan_mask = 8'hFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(lat);
    chk("t4_lat", lat, 2);
    held_data = bus.sample_data;
    chk("t4_data0", {28'd0, held_data}, 5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", {31'd0, bus.sample_valid}, 1);
      chk("t4_hold_data", {28'd0, bus.sample_data}, 5);
      chk("t4_hold_chan", {29'd0, bus.sample_chan}, 0);
      chk("t4_hold_sel", {29'd0, bus.s2, bus.s1, bus.s0}, 0);
    end
    bus.sample_ready = 1'b1;
    step();
    chk("t4_drop", {31'd0, bus.sample_valid}, 0);
    get_sample(1, 4, 0, 2);

    // 5: stop during SETTLE of channel 3
    do_reset();
    bus.chan_mask = 8'hFF;
    bus.sample_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    get_sample(0, 5, 0, 2);
    get_sample(1, 4, 0, 2);
    get_sample(2, 7, 0, 2);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    get_sample(3, 6, 0, 1);
    chk("t5_busy", {31'd0, bus.busy}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_idle_valid", {31'd0, bus.sample_valid}, 0);
      chk("t5_idle_busy", {31'd0, bus.busy}, 0);
      chk("t5_idle_sel", {29'd0, bus.s2, bus.s1, bus.s0}, 3);
    end

    // 6: empty mask ignored, then single channel 4 repeats with frame_done
    do_reset();
    bus.chan_mask = 8'h00;
    bus.sample_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t6_busy0", {31'd0, bus.busy}, 0);
    step();
    chk("t6_busy1", {31'd0, bus.busy}, 0);
    chk("t6_valid", {31'd0, bus.sample_valid}, 0);
    bus.chan_mask = 8'b0001_0000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) get_sample(4, 1, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
